pipeline_ctrl: RTL and testbench

Central pipeline sequencing controller for the five-stage core. It gathers stall requests from ID, EX and MEM and drives the `stop_all` bus consumed by `pc_reg` and every pipeline register. It also sequences exception flushes with a redirect PC, and runs a debug halt/drain/resume handshake. A watchdog flags stalls that never clear.

---
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stall decode onto stop_all, exception flush with
// redirect PC, debug halt/drain/resume handshake and a sticky stall watchdog.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned TIMEOUT_WIDTH = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop_request_id,
    input  logic        stop_request_ex,
    input  logic        stop_request_mem,
    input  logic        exception_valid,
    input  logic [31:0] exception_vector,
    input  logic        halt_request,
    output logic [5:0]  stop_all,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        halt_ack,
    output logic        stall_timeout
);

    localparam int unsigned DRAIN_W = 4;
    localparam logic [DRAIN_W-1:0]       DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX  = TIMEOUT_WIDTH'(STALL_TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALTING,
        ST_HALTED
    } state_t;

    state_t                   state, state_next;
    logic [DRAIN_W-1:0]       drain_cnt, drain_next;
    logic [TIMEOUT_WIDTH-1:0] stall_cnt;
    logic                     any_stall;
    logic                     pc_load;
    logic                     counting;
    logic [5:0]               decoded;

    // Deepest requesting stage determines how far back the freeze reaches
    always_comb begin
        any_stall = stop_request_id | stop_request_ex | stop_request_mem;
        if (stop_request_mem)      decoded = 6'b011111;
        else if (stop_request_ex)  decoded = 6'b001111;
        else if (stop_request_id)  decoded = 6'b000111;
        else                       decoded = 6'b000000;
    end

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        stop_all   = 6'b000000;
        pc_load    = 1'b0;
        case (state)
            ST_RUN: begin
                if (exception_valid) begin
                    state_next = ST_FLUSH;
                    pc_load    = 1'b1;
                end else begin
                    stop_all = decoded;
                    if (halt_request && !any_stall) begin
                        state_next = ST_HALTING;
                        drain_next = DRAIN_LOAD;
                    end
                end
            end
            ST_FLUSH: state_next = ST_RUN;
            ST_HALTING: begin
                stop_all = 6'b000011 | decoded;
                if (exception_valid) begin
                    state_next = ST_FLUSH;
                    pc_load    = 1'b1;
                end else if (!halt_request) begin
                    state_next = ST_RUN;
                end else if (!any_stall) begin
                    if (drain_cnt == '0) state_next = ST_HALTED;
                    else                 drain_next = drain_cnt - DRAIN_W'(1);
                end
            end
            ST_HALTED: begin
                stop_all = 6'b111111;
                if (!halt_request) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
        if (reset) stop_all = 6'b111111;
        counting = any_stall && (state == ST_RUN || state == ST_HALTING);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            flush     <= 1'b0;
            new_pc    <= 32'h0;
            halt_ack  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            flush     <= (state_next == ST_FLUSH);
            halt_ack  <= (state_next == ST_HALTED);
            if (pc_load) new_pc <= exception_vector;
        end
    end

    // Watchdog: saturating run-length of stalled cycles, flag is sticky until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (counting) begin
            if (stall_cnt != TIMEOUT_MAX) stall_cnt <= stall_cnt + TIMEOUT_WIDTH'(1);
            if (stall_cnt == TIMEOUT_LAST) stall_timeout <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model expectations per cycle,
// a monitor pops and compares against the DUT outputs.
module tb_pipeline_ctrl;

    localparam int DRAIN = 4;
    localparam int TMO   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stop_request_id = 1'b0, stop_request_ex = 1'b0, stop_request_mem = 1'b0;
    logic        exception_valid = 1'b0;
    logic [31:0] exception_vector = 32'h0;
    logic        halt_request = 1'b0;
    logic [5:0]  stop_all;
    logic        flush, halt_ack, stall_timeout;
    logic [31:0] new_pc;

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .STALL_TIMEOUT(TMO), .TIMEOUT_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .stop_request_id(stop_request_id), .stop_request_ex(stop_request_ex),
        .stop_request_mem(stop_request_mem),
        .exception_valid(exception_valid), .exception_vector(exception_vector),
        .halt_request(halt_request),
        .stop_all(stop_all), .flush(flush), .new_pc(new_pc),
        .halt_ack(halt_ack), .stall_timeout(stall_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  stop;
        logic        fl;
        logic [31:0] pc;
        logic        ack;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference model: halt/flush bookkeeping as plain flags and counts
    bit          m_flush, m_halting, m_halted, m_to;
    logic [31:0] m_pc;
    int          m_drain, m_stalls;

    task automatic cyc(input bit id, input bit ex, input bit mem, input bit exc,
                       input logic [31:0] vec, input bit hreq, input bit rst);
        exp_t e;
        logic [5:0] deep;
        bit anyst, active, nf, nhg, nhd;
        @(negedge clock);
        reset = rst; stop_request_id = id; stop_request_ex = ex; stop_request_mem = mem;
        exception_valid = exc; exception_vector = vec; halt_request = hreq;
        if (rst) begin
            m_flush = 0; m_halting = 0; m_halted = 0; m_to = 0; m_pc = 32'h0;
            m_drain = 0; m_stalls = 0;
            e.stop = 6'h3f; e.fl = 0; e.pc = 32'h0; e.ack = 0; e.to = 0;
            exp_q.push_back(e);
            return;
        end
        deep  = mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000;
        anyst = id | ex | mem;
        if (m_halted)       e.stop = 6'h3f;
        else if (m_flush)   e.stop = 6'h00;
        else if (m_halting) e.stop = 6'b000011 | deep;
        else                e.stop = exc ? 6'h00 : deep;
        e.fl = m_flush; e.pc = m_pc; e.ack = m_halted; e.to = m_to;
        exp_q.push_back(e);

        active = !m_halted && !m_flush;
        if (active && anyst) begin
            if (m_stalls < TMO) m_stalls++;
            if (m_stalls == TMO) m_to = 1;
        end else begin
            m_stalls = 0;
        end
        nf = 0; nhg = m_halting; nhd = m_halted;
        if (m_halted) begin
            if (!hreq) nhd = 0;
        end else if (m_flush) begin
            nf = 0;
        end else if (m_halting) begin
            if (exc) begin nf = 1; m_pc = vec; nhg = 0; end
            else if (!hreq) nhg = 0;
            else if (!anyst) begin
                if (m_drain == 0) begin nhd = 1; nhg = 0; end
                else m_drain--;
            end
        end else begin
            if (exc) begin nf = 1; m_pc = vec; end
            else if (hreq && !anyst) begin nhg = 1; m_drain = DRAIN - 1; end
        end
        m_flush = nf; m_halting = nhg; m_halted = nhd;
    endtask

    task automatic idle(input int n, input bit hreq);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0, hreq, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (stop_all !== e.stop || flush !== e.fl || halt_ack !== e.ack ||
                    stall_timeout !== e.to || (e.fl && new_pc !== e.pc)) begin
                    n_bad++;
                    $display("FAIL cycle%0d: got stop=%b flush=%b pc=%h ack=%b to=%b, want stop=%b flush=%b pc=%h ack=%b to=%b",
                             cyc_no, stop_all, flush, new_pc, halt_ack, stall_timeout,
                             e.stop, e.fl, e.pc, e.ack, e.to);
                end
                if (!e.fl && new_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL held_pc cycle%0d: got %h want %h", cyc_no, new_pc, e.pc);
                end
            end
        end
    end

    initial begin : driver
        bit h;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 0, 1);
        idle(2, 0);
        cyc(1, 0, 1, 0, 32'h0, 0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0, 0);
        idle(1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 32'h0, 0, 0);
        idle(2, 0);
        cyc(0, 1, 0, 1, 32'h00000180, 0, 0);
        idle(3, 0);
        idle(8, 1);
        idle(2, 0);
        idle(2, 1);
        cyc(0, 0, 1, 0, 32'h0, 1, 0);
        cyc(0, 0, 1, 0, 32'h0, 1, 0);
        idle(8, 1);
        idle(2, 0);
        idle(2, 1);
        cyc(0, 0, 0, 1, 32'h00000200, 1, 0);
        idle(10, 1);
        idle(2, 0);
        cyc(0, 0, 0, 1, 32'h00000300, 1, 0);
        idle(10, 1);
        idle(2, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 32'h0, 0, 0);
        idle(3, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        idle(2, 0);

        h = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) h = ~h;
            cyc($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
                $urandom_range(19) == 0, $urandom, h, $urandom_range(199) == 0);
        end
        idle(2, 0);
        @(negedge clock);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
